// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I func3 width/sign codes used by the unit (F3_B .. F3_HU)
//   - FSM state enum lsu_state_t
//   - func3_illegal(): func3 legality check for a load or a store
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_WR,
        S_DONE
    } lsu_state_t;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic func3_illegal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 > F3_W);
        end
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
// Ports:
//   offset_i   [1:0]  byte offset within the word (addr[1:0])
//   func3_i    [2:0]  RV32I width/sign code
//   word_i     [31:0] word read from memory
//   wdata_i    [31:0] store data (low byte/halfword used for B/H)
//   load_o     [31:0] extracted, sign/zero-extended load value
//   merge_o    [31:0] memory word with the store lane replaced (full wdata for W)
//   misalign_o        H with offset[0]=1, or W with offset!=0
// Lanes are taken from the offset aligned down to the access size, so a
// misaligned access that is allowed to proceed behaves as the aligned one.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o,
    output logic        misalign_o
);

    logic [1:0]  eff;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        eff = offset_i;
        case (func3_i[1:0])
            2'b01:   eff = {offset_i[1], 1'b0};
            2'b10:   eff = 2'b00;
            default: eff = offset_i;
        endcase

        misalign_o = ((func3_i[1:0] == 2'b01) && offset_i[0]) ||
                     ((func3_i[1:0] == 2'b10) && (offset_i != 2'b00));

        byte_v = word_i[{eff, 3'b000} +: 8];
        half_v = word_i[{eff[1], 4'b0000} +: 16];

        case (func3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'h0, byte_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = 32'h0;
        endcase

        merge_o = word_i;
        case (func3_i[1:0])
            2'b00:   merge_o[{eff, 3'b000} +: 8]    = wdata_i[7:0];
            2'b01:   merge_o[{eff[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a word-wide
// data memory. Sub-word stores are done as read-modify-write.
// Build option: LSU_MISALIGN_CHECK_EN -- when defined, misaligned H/W
// accesses complete with resp_err and touch no memory; otherwise the address
// is aligned down and the access proceeds.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_store, req_func3, req_addr, req_wdata   request payload
//   resp_valid, resp_rdata, resp_err            one-cycle completion
//   mem_read, mem_write, mem_func3, mem_addr, mem_wdata, mem_rdata  memory port
//
// state    | meaning
// S_IDLE   | ready, waiting for a request
// S_RD     | load: read word, register extracted lane
// S_RMW_RD | sub-word store: read word, merge store lane
// S_WR     | one-cycle write of the final word
// S_DONE   | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]  al_offset;
    logic [2:0]  al_func3;
    logic [31:0] al_load;
    logic [31:0] al_merge;
    logic        al_misalign;
    logic        req_bad;

    // In IDLE the aligner looks at the incoming request so the misalign
    // decision can be made at accept time; afterwards it works on the latches.
    assign al_offset = (state_q == S_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_func3  = (state_q == S_IDLE) ? req_func3     : func3_q;

    lsu_align u_align (
        .offset_i   (al_offset),
        .func3_i    (al_func3),
        .word_i     (mem_rdata),
        .wdata_i    (wdata_q),
        .load_o     (al_load),
        .merge_o    (al_merge),
        .misalign_o (al_misalign)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_bad = func3_illegal(req_store, req_func3) || al_misalign;
`else
    assign req_bad = func3_illegal(req_store, req_func3);
`endif

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (!req_store) begin
                        state_d = S_RD;
                    end else if (req_func3 == F3_W) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                rdata_d = al_load;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                wdata_d = al_merge;
                state_d = S_WR;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode directly from the async-reset state register, so a reset
    // during S_WR drops mem_write at once.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = (state_q == S_RD) || (state_q == S_RMW_RD);
    assign mem_write  = (state_q == S_WR);
    assign mem_wdata  = (state_q == S_WR) ? wdata_q : 32'h0;
    assign mem_func3  = func3_q;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_func3  (mem_func3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Issues one request (called at a negedge with the DUT idle) and records
    // what the memory port and response did; lat=99 means no response seen.
    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nwr, output logic [31:0] wword,
                           output logic [31:0] waddr, output int nrd, output logic rdy_done);
        req_valid = 1'b1; req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
        lat = 99; rd = 32'h0; er = 1'b0; nwr = 0; nrd = 0; wword = 32'h0; waddr = 32'h0;
        rdy_done = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_write) begin nwr++; wword = mem_wdata; waddr = mem_addr; end
            if (mem_read) nrd++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err; rdy_done = req_ready;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write}); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_func3 !== 3'b000) begin
            n_bad++; $display("FAIL reset_mem_bus addr=%h wdata=%h f3=%b exp all 0", mem_addr, mem_wdata, mem_func3); end
        n_cmp++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_resp rdata=%h err=%b exp 0/0", resp_rdata, resp_err); end
    endtask

    task automatic test_loads();
        int lat, nwr, nrd; logic [31:0] rd, ww, wa; logic er, rdy;
        logic [2:0]  f3s  [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        logic [31:0] adrs [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er, nwr, ww, wa, nrd, rdy);
            n_cmp++; if (rd !== exps[i] || er !== 1'b0) begin
                n_bad++; $display("FAIL load%0d_data got=%h err=%b exp=%h err=0", i, rd, er, exps[i]); end
            n_cmp++; if (lat !== 2 || nwr !== 0 || nrd !== 1 || rdy !== 1'b0) begin
                n_bad++; $display("FAIL load%0d_timing lat=%0d wr=%0d rd=%0d rdy=%b exp 2/0/1/0", i, lat, nwr, nrd, rdy); end
        end
    endtask

    task automatic test_errors();
        int lat, nwr, nrd; logic [31:0] rd, ww, wa; logic er, rdy;
        run_req(1'b0, F3_W, 32'h102, 32'h0, lat, rd, er, nwr, ww, wa, nrd, rdy);
`ifdef LSU_MISALIGN_CHECK_EN
        n_cmp++; if (er !== 1'b1 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
            n_bad++; $display("FAIL misalign_lw err=%b lat=%0d rd=%0d wr=%0d exp 1/1/0/0", er, lat, nrd, nwr); end
`else
        n_cmp++; if (er !== 1'b0 || lat !== 2 || rd !== 32'h8899AABB) begin
            n_bad++; $display("FAIL misalign_lw err=%b lat=%0d data=%h exp 0/2/8899aabb", er, lat, rd); end
`endif
        run_req(1'b0, 3'b011, 32'h100, 32'h0, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (er !== 1'b1 || lat !== 1 || nrd !== 0 || rd !== 32'h0) begin
            n_bad++; $display("FAIL illegal_load err=%b lat=%0d rd=%0d data=%h exp 1/1/0/0", er, lat, nrd, rd); end
        run_req(1'b1, 3'b100, 32'h100, 32'h5, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (er !== 1'b1 || lat !== 1 || nwr !== 0 || mem[8'h40] !== 32'h8899AABB) begin
            n_bad++; $display("FAIL illegal_store err=%b lat=%0d wr=%0d mem=%h exp 1/1/0/8899aabb", er, lat, nwr, mem[8'h40]); end
    endtask

    task automatic test_stores();
        int lat, nwr, nrd; logic [31:0] rd, ww, wa; logic er, rdy;
        run_req(1'b1, F3_B, 32'h102, 32'h12345677, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (ww !== 32'h8877AABB || wa !== 32'h100 || nwr !== 1) begin
            n_bad++; $display("FAIL sb_write word=%h addr=%h n=%0d exp 8877aabb/100/1", ww, wa, nwr); end
        n_cmp++; if (lat !== 3 || nrd !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            n_bad++; $display("FAIL sb_timing lat=%0d rd=%0d err=%b data=%h exp 3/1/0/0", lat, nrd, er, rd); end
        n_cmp++; if (mem[8'h40] !== 32'h8877AABB) begin
            n_bad++; $display("FAIL sb_mem got=%h exp=8877aabb", mem[8'h40]); end
        run_req(1'b1, F3_W, 32'h104, 32'hDEADBEEF, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (ww !== 32'hDEADBEEF || wa !== 32'h104 || nwr !== 1 || nrd !== 0 || lat !== 2) begin
            n_bad++; $display("FAIL sw word=%h addr=%h wr=%0d rd=%0d lat=%0d exp deadbeef/104/1/0/2", ww, wa, nwr, nrd, lat); end
        run_req(1'b0, F3_W, 32'h104, 32'h0, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
        run_req(1'b1, F3_H, 32'h106, 32'h0000CAFE, lat, rd, er, nwr, ww, wa, nrd, rdy);
        n_cmp++; if (mem[8'h41] !== 32'hCAFEBEEF || lat !== 3) begin
            n_bad++; $display("FAIL sh_upper mem=%h lat=%0d exp cafebeef/3", mem[8'h41], lat); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] rdy_seq, rv_seq;
        req_valid = 1'b1; req_store = 1'b0; req_func3 = F3_BU; req_addr = 32'h103; req_wdata = 32'h0;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rdy_seq[k] = req_ready; rv_seq[k] = resp_valid;
        end
        req_valid = 1'b0;
        @(negedge clk);
        // RD, DONE (request held but refused), IDLE (re-accept), RD, DONE
        n_cmp++; if (rdy_seq !== 5'b00100 || rv_seq !== 5'b10010) begin
            n_bad++; $display("FAIL back_to_back ready=%b resp=%b exp 00100/10010", rdy_seq, rv_seq); end
        n_cmp++; if (resp_rdata !== 32'h00000088 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL back_to_back_end data=%h rdy=%b exp 00000088/1", resp_rdata, req_ready); end
    endtask

    task automatic test_reset_in_wr();
        logic wr_seen;
        req_valid = 1'b1; req_store = 1'b1; req_func3 = F3_H; req_addr = 32'h100; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_seen = mem_write;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_seen !== 1'b1 || mem_write !== 1'b0 || mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_in_wr before=%b after=%b wdata=%h exp 1/0/0", wr_seen, mem_write, mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem[8'h40] !== 32'h8877AABB || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_wr_after mem=%h rdy=%b rv=%b exp 8877aabb/1/0", mem[8'h40], req_ready, resp_valid); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_loads();
        test_errors();
        test_stores();
        test_back_to_back();
        test_reset_in_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
